// File: rtl/id_issue_ctrl.sv
// Issue controller between decode and execute: pending-write scoreboard,
// RAW/WAW hazard stall, in-flight writer cap, post-flush bubble window.
module id_issue_ctrl #(
  parameter int REG_AW        = 5,
  parameter int MAX_INFLIGHT  = 4,
  parameter int FLUSH_BUBBLES = 2,
  parameter int STALL_CW      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic                    rs1_en,
  input  logic [REG_AW-1:0]       rs1,
  input  logic                    rs2_en,
  input  logic [REG_AW-1:0]       rs2,
  input  logic                    rd_en,
  input  logic [REG_AW-1:0]       rd,
  input  logic                    ex_ready,
  input  logic                    wb_en,
  input  logic [REG_AW-1:0]       wb_rd,
  input  logic                    flush,
  output logic                    id_ready,
  output logic                    stall,
  output logic                    ex_valid,
  output logic                    ex_rd_en,
  output logic [REG_AW-1:0]       ex_rd,
  output logic [(2**REG_AW)-1:0]  pending,
  output logic [3:0]              inflight,
  output logic [STALL_CW-1:0]     stall_cnt
);
  localparam int NREG = 2 ** REG_AW;

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          bubble_cnt_reg, bubble_cnt_next;
  logic [NREG-1:0]     pending_reg, pending_next;
  logic [NREG-1:0]     eff_pending, set_mask, clr_mask;
  logic [3:0]          inflight_reg, inflight_next;
  logic [STALL_CW-1:0] stall_cnt_reg;
  logic                ex_valid_reg, ex_rd_en_reg;
  logic [REG_AW-1:0]   ex_rd_reg;
  logic                rd_live, hazard, limit, slot_free, issue, writer_issue, wb_dec;

  assign rd_live = rd_en && (rd != '0);
  assign wb_dec  = wb_en && (wb_rd != '0);

  // Write-through register file: a writeback landing this cycle already resolves the hazard.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    assign clr_mask[gi]    = wb_en && (wb_rd == REG_AW'(gi));
    assign set_mask[gi]    = writer_issue && (rd == REG_AW'(gi));
    assign eff_pending[gi] = pending_reg[gi] & ~clr_mask[gi];
  end

  assign hazard = (rs1_en && eff_pending[rs1]) ||
                  (rs2_en && eff_pending[rs2]) ||
                  (rd_live && eff_pending[rd]);
  assign slot_free    = !ex_valid_reg || ex_ready;
  assign limit        = rd_live && (inflight_reg == 4'(MAX_INFLIGHT)) && !wb_en;
  assign issue        = id_valid && !flush && (state_reg == RUN) && !hazard && !limit && slot_free;
  assign writer_issue = issue && rd_live;
  assign id_ready     = issue || (id_valid && flush);
  assign stall        = id_valid && !flush && !issue;

  always_comb begin
    state_next      = state_reg;
    bubble_cnt_next = bubble_cnt_reg;
    case (state_reg)
      RUN: begin
        if (flush) begin
          state_next      = BUBBLE;
          bubble_cnt_next = 3'(FLUSH_BUBBLES);
        end
      end
      BUBBLE: begin
        if (flush) begin
          bubble_cnt_next = 3'(FLUSH_BUBBLES);
        end else if (bubble_cnt_reg <= 3'd1) begin
          state_next      = RUN;
          bubble_cnt_next = 3'd0;
        end else begin
          bubble_cnt_next = bubble_cnt_reg - 3'd1;
        end
      end
      default: begin
        state_next      = RUN;
        bubble_cnt_next = 3'd0;
      end
    endcase
  end

  // Set after clear so a same-cycle issue to the written-back register keeps it pending.
  always_comb begin
    pending_next    = (pending_reg & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
    inflight_next   = inflight_reg;
    if (writer_issue && !wb_dec) begin
      if (inflight_reg < 4'(MAX_INFLIGHT)) inflight_next = inflight_reg + 4'd1;
    end else if (!writer_issue && wb_dec) begin
      if (inflight_reg != 4'd0) inflight_next = inflight_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      bubble_cnt_reg <= 3'd0;
      pending_reg    <= '0;
      inflight_reg   <= 4'd0;
      stall_cnt_reg  <= '0;
      ex_valid_reg   <= 1'b0;
      ex_rd_en_reg   <= 1'b0;
      ex_rd_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      bubble_cnt_reg <= bubble_cnt_next;
      pending_reg    <= pending_next;
      inflight_reg   <= inflight_next;
      if (stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (issue) begin
        ex_valid_reg <= 1'b1;
        ex_rd_en_reg <= rd_live;
        ex_rd_reg    <= rd;
      end else if (ex_ready) begin
        ex_valid_reg <= 1'b0;
      end
    end
  end

  assign ex_valid  = ex_valid_reg;
  assign ex_rd_en  = ex_rd_en_reg;
  assign ex_rd     = ex_rd_reg;
  assign pending   = pending_reg;
  assign inflight  = inflight_reg;
  assign stall_cnt = stall_cnt_reg;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: hazards, x0, set/clear race, writer cap,
// flush bubbles, backpressure and asynchronous reset.
module tb_id_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, rs1_en, rs2_en, rd_en, ex_ready, wb_en, flush;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        id_ready, stall, ex_valid, ex_rd_en;
  logic [4:0]  ex_rd;
  logic [31:0] pending;
  logic [3:0]  inflight;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  id_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2),
    .rd_en(rd_en), .rd(rd), .ex_ready(ex_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush),
    .id_ready(id_ready), .stall(stall), .ex_valid(ex_valid),
    .ex_rd_en(ex_rd_en), .ex_rd(ex_rd), .pending(pending),
    .inflight(inflight), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_valid = 0; rs1_en = 0; rs1 = 0; rs2_en = 0; rs2 = 0;
    rd_en = 0; rd = 0; ex_ready = 1; wb_en = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_pending", pending, 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // RAW on x5
    id_valid = 1; rd_en = 1; rd = 5;
    #1 chk("raw_w_ready", 32'(id_ready), 1);
    cyc();
    chk("raw_w_exvalid", 32'(ex_valid), 1);
    chk("raw_w_exrd", 32'(ex_rd), 5);
    chk("raw_w_pending", pending, 32'h20);
    chk("raw_w_inflight", 32'(inflight), 1);
    rd_en = 0; rs1_en = 1; rs1 = 5;
    #1 chk("raw_stall", 32'(stall), 1);
    chk("raw_ready0", 32'(id_ready), 0);
    cyc();
    chk("raw_stall_cnt", 32'(stall_cnt), 1);
    chk("raw_exvalid0", 32'(ex_valid), 0);
    wb_en = 1; wb_rd = 5;
    #1 chk("raw_wb_ready", 32'(id_ready), 1);
    chk("raw_wb_stall", 32'(stall), 0);
    cyc();
    chk("raw_wb_exvalid", 32'(ex_valid), 1);
    chk("raw_wb_exrden", 32'(ex_rd_en), 0);
    chk("raw_wb_pending", pending, 0);
    chk("raw_wb_inflight", 32'(inflight), 0);
    idle(); cyc();

    // x0 writer then x0 reader
    id_valid = 1; rd_en = 1; rd = 0;
    #1 chk("x0_w_ready", 32'(id_ready), 1);
    cyc();
    chk("x0_exrden", 32'(ex_rd_en), 0);
    chk("x0_pending", pending, 0);
    rd_en = 0; rs1_en = 1; rs1 = 0;
    #1 chk("x0_r_ready", 32'(id_ready), 1);
    cyc();
    chk("x0_r_exvalid", 32'(ex_valid), 1);
    chk("x0_inflight", 32'(inflight), 0);
    idle(); cyc();

    // same-cycle set/clear on x7
    id_valid = 1; rd_en = 1; rd = 7;
    cyc();
    chk("sc_pend_a", pending, 32'h80);
    wb_en = 1; wb_rd = 7;
    #1 chk("sc_ready", 32'(id_ready), 1);
    cyc();
    chk("sc_pend_b", pending, 32'h80);
    chk("sc_inflight", 32'(inflight), 1);
    idle(); wb_en = 1; wb_rd = 7;
    cyc();
    chk("sc_pend_c", pending, 0);
    chk("sc_inflight0", 32'(inflight), 0);
    idle();

    // writer cap
    id_valid = 1; rd_en = 1;
    for (int r = 1; r <= 4; r++) begin
      rd = 5'(r);
      cyc();
    end
    chk("lim_inflight", 32'(inflight), 4);
    chk("lim_pending", pending, 32'h1E);
    rd = 6;
    #1 chk("lim_stall", 32'(stall), 1);
    chk("lim_ready0", 32'(id_ready), 0);
    cyc();
    chk("lim_stall_cnt", 32'(stall_cnt), 2);
    rd_en = 0;
    #1 chk("lim_nonwr_rdy", 32'(id_ready), 1);
    cyc();
    rd_en = 1; rd = 6; wb_en = 1; wb_rd = 1;
    #1 chk("lim_wb_ready", 32'(id_ready), 1);
    cyc();
    chk("lim_wb_inflt", 32'(inflight), 4);
    chk("lim_wb_pend", pending, 32'h5C);
    idle(); wb_en = 1;
    for (int r = 2; r <= 6; r++) begin
      if (r != 5) begin
        wb_rd = 5'(r);
        cyc();
      end
    end
    chk("lim_drain_pend", pending, 0);
    chk("lim_drain_infl", 32'(inflight), 0);
    idle(); cyc();

    // flush then two bubble cycles
    id_valid = 1; flush = 1;
    #1 chk("fl_ready", 32'(id_ready), 1);
    chk("fl_stall", 32'(stall), 0);
    cyc();
    chk("fl_exvalid", 32'(ex_valid), 0);
    flush = 0;
    #1 chk("fl_bub1", 32'(stall), 1);
    cyc();
    chk("fl_bub2", 32'(stall), 1);
    cyc();
    chk("fl_run_ready", 32'(id_ready), 1);
    cyc();
    chk("fl_exvalid1", 32'(ex_valid), 1);
    chk("fl_stall_cnt", 32'(stall_cnt), 4);
    idle(); cyc();

    // backpressure hold, then async reset mid-hold
    id_valid = 1; rd_en = 1; rd = 9;
    cyc();
    chk("bp_exrd", 32'(ex_rd), 9);
    ex_ready = 0; rd_en = 0;
    #1 chk("bp_stall", 32'(stall), 1);
    cyc();
    chk("bp_exvalid", 32'(ex_valid), 1);
    chk("bp_exrd_hold", 32'(ex_rd), 9);
    chk("bp_stall_cnt", 32'(stall_cnt), 5);
    #2 rst_n = 0;
    #1;
    chk("ar_exvalid", 32'(ex_valid), 0);
    chk("ar_exrd", 32'(ex_rd), 0);
    chk("ar_pending", pending, 0);
    chk("ar_inflight", 32'(inflight), 0);
    chk("ar_stall_cnt", 32'(stall_cnt), 0);
    idle();
    cyc();
    rst_n = 1;
    wb_en = 1; wb_rd = 9;
    cyc();
    chk("ar_stale_pend", pending, 0);
    chk("ar_stale_infl", 32'(inflight), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
Issue controller between the combinational instruction decoder and the execute stage. It holds a per-register pending-write scoreboard and detects RAW/WAW hazards on the decoder's rs1/rs2/rd outputs. It stalls or issues the decode slot into a registered EX handshake, caps the number of in-flight register writers, and inserts a fixed bubble window after a branch flush. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_AW, 5, register address width (matches XREG_ADDRWIDTH).
MAX_INFLIGHT, 4, maximum issued-but-not-written-back instructions with rd_en and rd!=0 (1..15).
FLUSH_BUBBLES, 2, cycles issue is blocked after flush (1..7).
STALL_CW, 16, width of stall cycle counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a valid instruction
rs1_en  in  1  instruction reads rs1
rs1  in  REG_AW  source register 1
rs2_en  in  1  instruction reads rs2
rs2  in  REG_AW  source register 2
rd_en  in  1  instruction writes rd
rd  in  REG_AW  destination register
ex_ready  in  1  EX accepts the current ex_valid slot
wb_en  in  1  writeback of a register this cycle
wb_rd  in  REG_AW  writeback destination
flush  in  1  branch redirect; squash decode slot
id_ready  out  1  decode slot consumed this cycle (combinational)
stall  out  1  id_valid held due to hazard/limit/bubble (combinational)
ex_valid  out  1  registered issue valid to EX
ex_rd_en  out  1  registered rd_en of issued instruction
ex_rd  out  REG_AW  registered rd of issued instruction
pending  out  2**REG_AW  scoreboard, bit n = write to xn outstanding
inflight  out  4  count of outstanding writers
stall_cnt  out  STALL_CW  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, ex_rd_en=0, ex_rd=0, pending=0, inflight=0, stall_cnt=0, FSM=RUN, bubble counter=0. Reset mid-stream discards all outstanding state; stale wb_en after reset only clears bits (harmless). inflight never underflows (decrement at 0 ignored).
- FSM states: RUN, BUBBLE. RUN->BUBBLE on flush, loading bubble_cnt=FLUSH_BUBBLES. In BUBBLE, decrement each cycle; ->RUN when count reaches 1. A flush in BUBBLE reloads FLUSH_BUBBLES.
- eff_pending[n] = pending[n] & ~(wb_en & wb_rd==n). The register file is write-through, so a same-cycle writeback resolves the hazard.
- hazard = (rs1_en & eff_pending[rs1]) | (rs2_en & eff_pending[rs2]) | (rd_en & rd!=0 & eff_pending[rd]). Register x0 never hazards; pending[0] is constant 0.
- slot_free = ~ex_valid | ex_ready.
- limit = (rd_en & rd!=0) & (inflight==MAX_INFLIGHT) & ~wb_en.
- issue = id_valid & ~flush & FSM==RUN & ~hazard & ~limit & slot_free.
- id_ready = issue | (id_valid & flush). On flush, the slot is dropped and nothing is issued.
- stall = id_valid & ~flush & ~issue.
- EX register: on issue, ex_valid<=1, ex_rd_en<=rd_en & rd!=0, ex_rd<=rd. Otherwise, if ex_ready, ex_valid<=0. Otherwise hold. Flush does not affect the EX slot, because the EX instruction is older.
- Scoreboard:
  - Issue with rd_en & rd!=0 sets pending[rd].
  - wb_en clears pending[wb_rd].
  - If both target the same rd in the same cycle, set wins.
- inflight: +1 on writer issue and -1 on wb_en with wb_rd!=0. Both together leave it unchanged. Bounded at 0..MAX_INFLIGHT.
- stall_cnt: +1 each cycle stall=1, saturating at all-ones.
- Latency: issue decision is same-cycle combinational; ex_valid appears the next rising edge.

Test Plan:
- RAW: issue "rd=5" (ex_ready=1), next cycle id_valid rs1_en rs1=5, no wb -> stall=1, id_ready=0, pending[5]=1. Then wb_en wb_rd=5 -> issue same cycle, ex_valid=1 next edge.
- x0: rd_en rd=0 followed by rs1=0 reader -> back-to-back issue, pending stays 0, inflight stays 0.
- Same-cycle set/clear: pending[7]=1, issue rd=7 while wb_en wb_rd=7 -> pending[7]=1 after edge, inflight unchanged.
- Limit: 4 writers rd=1..4 issued with no wb -> inflight=4. A 5th writer rd=6 stalls; a non-writer (rd_en=0) issues. wb_rd=1 -> 5th issues that cycle.
- Flush: flush=1 with id_valid -> id_ready=1, no ex_valid. Next 2 cycles stall=1 with id_valid; 3rd cycle issues. stall_cnt incremented by 2.
- Backpressure and reset: ex_valid=1, ex_ready=0 -> ex_valid/ex_rd hold, new instruction stalls. Assert rst_n=0 mid-hold -> all outputs 0 immediately without clock edge.
